rbm_hidden_sched: RTL and testbench

Sequencer for the minimal RBM forward pass: on a start request from the AXI-Lite control registers it iterates hidden units j = 0..h_dim-1, requests each weight column/bias from the column fetch wrapper, runs one `rbm_core_min` GEMV+sigmoid per unit, samples a binary hidden state, and writes probability and sample into the hidden buffer. It sits between `rbm_ctrl_axi_lite` (control/status) and the `rbm_core_min` datapath, and drives the STATUS busy/done/err bits.

---
 rtl/rbm_pkg.sv | 31 +++
 rtl/rbm_hsample.sv | 18 +
 rtl/rbm_hidden_sched.sv | 199 +++++++++++++++++++
 tb/tb_rbm_hidden_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_pkg.sv
// Shared constants for the RBM forward-pass sequencer: state codes, status bit
// positions and Q0.16 helpers.
package rbm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DIM_W   = 16;
  localparam int unsigned P_W     = 16;
  localparam int unsigned CYC_W   = 32;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd2;
  localparam logic [STATE_W-1:0] ST_START = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;
  localparam logic [STATE_W-1:0] ST_ERR   = 3'd7;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_ERR_BIT  = 2;

  localparam logic [P_W-1:0] Q16_HALF = 16'h8000;

  // States in which a run is in progress and cycles are billed.
  function automatic logic is_busy_state(input logic [STATE_W-1:0] s);
    return (s == ST_CHECK) || (s == ST_FETCH) || (s == ST_START) ||
           (s == ST_WAIT)  || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/rbm_hsample.sv
// Binary hidden-state sampler: threshold at one half, or Bernoulli against an
// external uniform random value.
module rbm_hsample
  import rbm_pkg::*;
(
  input  logic [P_W-1:0] p,
  input  logic [P_W-1:0] rnd,
  input  logic           determ,
  output logic           hbit_c
);

  always_comb begin
    hbit_c = 1'b0;
    if (determ) hbit_c = (p >= Q16_HALF);
    else        hbit_c = (rnd < p);
  end

endmodule

// File: rtl/rbm_hidden_sched.sv
// Hidden-unit sequencer: walks j = 0..h_dim-1 through column fetch, core GEMV,
// sampling and hidden-buffer write, and maintains the run status.
module rbm_hidden_sched
  import rbm_pkg::*;
#(
  parameter int unsigned I_DIM   = 256,
  parameter int unsigned H_MAX   = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             ctrl_start,
  input  logic             ctrl_soft_rst,
  input  logic             ctrl_determ,
  input  logic [DIM_W-1:0] i_dim,
  input  logic [DIM_W-1:0] h_dim,
  input  logic [P_W-1:0]   rnd,
  output logic             col_req,
  output logic [DIM_W-1:0] col_idx,
  input  logic             col_ack,
  output logic             core_start,
  input  logic             core_busy,
  input  logic [P_W-1:0]   core_p,
  output logic             hbuf_we,
  output logic [DIM_W-1:0] hbuf_addr,
  output logic [P_W-1:0]   hbuf_prob,
  output logic             hbuf_bit,
  output logic             stat_busy,
  output logic             stat_done,
  output logic             stat_err,
  output logic [CYC_W-1:0] stat_cycles
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state, state_n;
  logic               start_q;
  logic [DIM_W-1:0]   j, j_n;
  logic [TO_W-1:0]    tcnt, tcnt_n;
  logic [DIM_W-1:0]   h_lat, h_lat_n;
  logic [DIM_W-1:0]   i_lat, i_lat_n;
  logic               done_n, err_n;
  logic [CYC_W-1:0]   cycles_n;
  logic [DIM_W-1:0]   addr_n;
  logic [P_W-1:0]     prob_n;
  logic               bit_n;
  logic               sample_c;

  rbm_hsample u_hsample (
    .p      (core_p),
    .rnd    (rnd),
    .determ (ctrl_determ),
    .hbit_c (sample_c)
  );

  // Next state, loop index, timeout count and next values of registered outputs.
  always_comb begin
    state_n  = state;
    j_n      = j;
    tcnt_n   = tcnt;
    h_lat_n  = h_lat;
    i_lat_n  = i_lat;
    done_n   = stat_done;
    err_n    = stat_err;
    cycles_n = stat_cycles;
    addr_n   = hbuf_addr;
    prob_n   = hbuf_prob;
    bit_n    = hbuf_bit;

    if (is_busy_state(state) && (stat_cycles != '1)) begin
      cycles_n = stat_cycles + CYC_W'(1);
    end

    unique case (state)
      ST_IDLE: begin
        if (ctrl_start && !start_q) begin
          state_n  = ST_CHECK;
          j_n      = '0;
          done_n   = 1'b0;
          err_n    = 1'b0;
          cycles_n = '0;
          h_lat_n  = h_dim;
          i_lat_n  = i_dim;
        end
      end
      ST_CHECK: begin
        if ((h_lat == '0) || (h_lat > DIM_W'(H_MAX)) || (i_lat != DIM_W'(I_DIM))) begin
          state_n = ST_ERR;
        end else begin
          state_n = ST_FETCH;
          tcnt_n  = '0;
        end
      end
      ST_FETCH: begin
        if (col_ack) begin
          state_n = ST_START;
        end else if (tcnt == TO_LAST) begin
          state_n = ST_ERR;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
      end
      ST_START: begin
        state_n = ST_WAIT;
        tcnt_n  = '0;
      end
      ST_WAIT: begin
        // The first non-busy cycle is the capture cycle for p and rnd.
        if (!core_busy) begin
          state_n = ST_WRITE;
          addr_n  = j;
          prob_n  = core_p;
          bit_n   = sample_c;
        end else if (tcnt == TO_LAST) begin
          state_n = ST_ERR;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
      end
      ST_WRITE: begin
        if (j == (h_lat - DIM_W'(1))) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_FETCH;
          j_n     = j + DIM_W'(1);
          tcnt_n  = '0;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_DONE) done_n = 1'b1;
    if (state_n == ST_ERR)  err_n  = 1'b1;
  end

  // State and registered outputs; soft reset clears everything except the
  // start sampler, which tracks ctrl_start so release cannot look like an edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      j           <= '0;
      tcnt        <= '0;
      h_lat       <= '0;
      i_lat       <= '0;
      col_req     <= 1'b0;
      col_idx     <= '0;
      core_start  <= 1'b0;
      hbuf_we     <= 1'b0;
      hbuf_addr   <= '0;
      hbuf_prob   <= '0;
      hbuf_bit    <= 1'b0;
      stat_busy   <= 1'b0;
      stat_done   <= 1'b0;
      stat_err    <= 1'b0;
      stat_cycles <= '0;
    end else if (ctrl_soft_rst) begin
      state       <= ST_IDLE;
      start_q     <= ctrl_start;
      j           <= '0;
      tcnt        <= '0;
      h_lat       <= '0;
      i_lat       <= '0;
      col_req     <= 1'b0;
      col_idx     <= '0;
      core_start  <= 1'b0;
      hbuf_we     <= 1'b0;
      hbuf_addr   <= '0;
      hbuf_prob   <= '0;
      hbuf_bit    <= 1'b0;
      stat_busy   <= 1'b0;
      stat_done   <= 1'b0;
      stat_err    <= 1'b0;
      stat_cycles <= '0;
    end else begin
      state       <= state_n;
      start_q     <= ctrl_start;
      j           <= j_n;
      tcnt        <= tcnt_n;
      h_lat       <= h_lat_n;
      i_lat       <= i_lat_n;
      col_req     <= (state_n == ST_FETCH);
      col_idx     <= j_n;
      core_start  <= (state_n == ST_START);
      hbuf_we     <= (state_n == ST_WRITE);
      hbuf_addr   <= addr_n;
      hbuf_prob   <= prob_n;
      hbuf_bit    <= bit_n;
      stat_busy   <= is_busy_state(state_n);
      stat_done   <= done_n;
      stat_err    <= err_n;
      stat_cycles <= cycles_n;
    end
  end

endmodule

// File: tb/tb_rbm_hidden_sched.sv
// Scoreboard bench for rbm_hidden_sched with behavioural column-fetch and core models.
module tb_rbm_hidden_sched;

  localparam int I_DIM   = 8;
  localparam int H_MAX   = 64;
  localparam int TIMEOUT = 1024;
  localparam int NO_ACK  = 1000000;

  logic        ACLK, ARESETn;
  logic        ctrl_start, ctrl_soft_rst, ctrl_determ;
  logic [15:0] i_dim, h_dim, rnd;
  logic        col_req, col_ack, core_start, core_busy;
  logic [15:0] col_idx, core_p;
  logic        hbuf_we, hbuf_bit;
  logic [15:0] hbuf_addr, hbuf_prob;
  logic        stat_busy, stat_done, stat_err;
  logic [31:0] stat_cycles;

  rbm_hidden_sched #(.I_DIM(I_DIM), .H_MAX(H_MAX), .TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ctrl_start(ctrl_start), .ctrl_soft_rst(ctrl_soft_rst),
    .ctrl_determ(ctrl_determ), .i_dim(i_dim), .h_dim(h_dim), .rnd(rnd),
    .col_req(col_req), .col_idx(col_idx), .col_ack(col_ack),
    .core_start(core_start), .core_busy(core_busy), .core_p(core_p),
    .hbuf_we(hbuf_we), .hbuf_addr(hbuf_addr), .hbuf_prob(hbuf_prob), .hbuf_bit(hbuf_bit),
    .stat_busy(stat_busy), .stat_done(stat_done), .stat_err(stat_err), .stat_cycles(stat_cycles)
  );

  typedef struct {
    int          addr;
    logic [15:0] prob;
    logic        hbit;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] pq[$];
  logic [15:0] rq[$];
  wr_t         mon_e;

  int tests = 0, fails = 0;
  int writes_seen = 0, fetch_cycles = 0, runs_seen = 0, idx_bad = 0;
  int ack_delay = 0, ack_cnt = 0, busy_cnt = 0;
  logic prev_busy = 1'b0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Column fetch model: ack arrives after ack_delay cycles of continuous request.
  always @(negedge ACLK) begin
    if (col_req) begin
      ack_cnt++;
      col_ack = (ack_cnt > ack_delay);
    end else begin
      ack_cnt = 0;
      col_ack = 1'b0;
    end
  end

  // Core model: busy the cycle after core_start, result valid I_DIM+2 cycles into WAIT.
  // p and rnd are noise except in the result cycle, where the planned values appear.
  always @(negedge ACLK) begin
    if (core_start) begin
      busy_cnt  = I_DIM + 2;
      core_busy = 1'b1;
      core_p    = 16'($urandom);
      rnd       = 16'($urandom);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        core_busy = 1'b0;
        core_p    = (pq.size() > 0) ? pq.pop_front() : 16'($urandom);
        rnd       = (rq.size() > 0) ? rq.pop_front() : 16'($urandom);
      end else begin
        core_p = 16'($urandom);
        rnd    = 16'($urandom);
      end
    end else begin
      core_p = 16'($urandom);
      rnd    = 16'($urandom);
    end
  end

  // Monitor: pops the scoreboard on every buffer write and tracks fetch/run activity.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (hbuf_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d written, no write expected", hbuf_addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("hbuf_addr", 64'(hbuf_addr), 64'(mon_e.addr));
          check("hbuf_prob", 64'(hbuf_prob), 64'(mon_e.prob));
          check("hbuf_bit",  64'(hbuf_bit),  64'(mon_e.hbit));
        end
      end
      if (col_req) begin
        fetch_cycles++;
        if (col_idx != 16'(writes_seen)) idx_bad++;
      end
      if (stat_busy && !prev_busy) runs_seen++;
    end
    prev_busy = stat_busy;
  end

  function automatic void clear_plan();
    pq.delete();
    rq.delete();
    exp_q.delete();
  endfunction

  // Reference: threshold at one half, or rnd strictly below p.
  function automatic void plan_unit(input int addr, input logic [15:0] p, input logic [15:0] r,
                                    input bit det, input bit expect_write);
    wr_t e;
    pq.push_back(p);
    rq.push_back(r);
    if (expect_write) begin
      e.addr = addr;
      e.prob = p;
      e.hbit = det ? (int'(p) >= 32768) : (int'(r) < int'(p));
      exp_q.push_back(e);
    end
  endfunction

  function automatic void plan_random(input int h, input bit det, input int n_exp);
    for (int k = 0; k < h; k++) plan_unit(k, 16'($urandom), 16'($urandom), det, k < n_exp);
  endfunction

  task automatic setup(input int h, input int idim, input bit det, input int delay);
    h_dim       = 16'(h);
    i_dim       = 16'(idim);
    ctrl_determ = det;
    ack_delay   = delay;
  endtask

  task automatic start_pulse(input bit hold);
    @(negedge ACLK);
    writes_seen  = 0;
    fetch_cycles = 0;
    runs_seen    = 0;
    idx_bad      = 0;
    ctrl_start   = 1'b1;
    @(negedge ACLK);
    if (!hold) ctrl_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(stat_done || stat_err) && n < 5000) begin
      @(negedge ACLK);
      n++;
    end
    if (!(stat_done || stat_err)) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done/err after %0d cycles", name, n);
    end
  endtask

  task automatic check_end(input string name, input bit done, input bit err,
                           input int cycles, input int writes);
    check({name, "_done"},    64'(stat_done), 64'(done));
    check({name, "_err"},     64'(stat_err), 64'(err));
    check({name, "_busy"},    64'(stat_busy), 64'(0));
    check({name, "_cycles"},  64'(stat_cycles), 64'(cycles));
    check({name, "_writes"},  64'(writes_seen), 64'(writes));
    check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
    check({name, "_col_idx"}, 64'(idx_bad), 64'(0));
    check({name, "_runs"},    64'(runs_seen), 64'(1));
  endtask

  task automatic dim_error(input string name, input int h, input int idim);
    clear_plan();
    setup(h, idim, 1'b0, 0);
    start_pulse(1'b0);
    @(posedge ACLK);
    #1;
    check({name, "_err_2cyc"}, 64'(stat_err), 64'(1));
    check({name, "_col_req"},  64'(fetch_cycles), 64'(0));
    repeat (3) @(negedge ACLK);
    check_end(name, 1'b0, 1'b1, 1, 0);
  endtask

  task automatic normal_run(input string name, input int h, input bit det, input int delay);
    clear_plan();
    setup(h, I_DIM, det, delay);
    plan_random(h, det, h);
    start_pulse(1'b0);
    wait_end(name);
    check_end(name, 1'b1, 1'b0, 1 + h * (I_DIM + 5 + delay), h);
  endtask

  initial begin
    int n;
    ARESETn = 1'b0; ctrl_start = 1'b0; ctrl_soft_rst = 1'b0; ctrl_determ = 1'b0;
    i_dim = 16'(I_DIM); h_dim = 16'd1; rnd = '0; core_p = '0; core_busy = 1'b0; col_ack = 1'b0;

    repeat (3) @(negedge ACLK);
    check("rst_col_req", 64'(col_req), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_hbuf_we", 64'(hbuf_we), 64'(0));
    check("rst_status", 64'({stat_busy, stat_done, stat_err}), 64'(0));
    check("rst_cycles", 64'(stat_cycles), 64'(0));
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    normal_run("basic_h4", 4, 1'b0, 0);

    dim_error("h0", 0, I_DIM);
    dim_error("h65", H_MAX + 1, I_DIM);
    dim_error("idim7", 4, I_DIM - 1);

    // Threshold sampling around one half.
    clear_plan();
    setup(2, I_DIM, 1'b1, 0);
    plan_unit(0, 16'h7FFF, 16'($urandom), 1'b1, 1'b1);
    plan_unit(1, 16'h8000, 16'($urandom), 1'b1, 1'b1);
    start_pulse(1'b0);
    wait_end("determ");
    check_end("determ", 1'b1, 1'b0, 1 + 2 * (I_DIM + 5), 2);

    // Stochastic sampling with rnd one below / equal to p.
    clear_plan();
    setup(2, I_DIM, 1'b0, 0);
    plan_unit(0, 16'h1001, 16'h1000, 1'b0, 1'b1);
    plan_unit(1, 16'h1000, 16'h1000, 1'b0, 1'b1);
    start_pulse(1'b0);
    wait_end("stoch");
    check_end("stoch", 1'b1, 1'b0, 1 + 2 * (I_DIM + 5), 2);

    normal_run("ack_delay5", 3, 1'b0, 5);

    // Column never acknowledged: error after TIMEOUT fetch cycles.
    clear_plan();
    setup(2, I_DIM, 1'b0, NO_ACK);
    start_pulse(1'b0);
    wait_end("no_ack");
    check("no_ack_fetch_cycles", 64'(fetch_cycles), 64'(TIMEOUT));
    check_end("no_ack", 1'b0, 1'b1, 1 + TIMEOUT, 0);
    @(negedge ACLK);

    // Start held high across completion must not retrigger.
    clear_plan();
    setup(2, I_DIM, 1'b1, 0);
    plan_random(2, 1'b1, 2);
    start_pulse(1'b1);
    wait_end("hold");
    repeat (30) @(negedge ACLK);
    check_end("hold", 1'b1, 1'b0, 1 + 2 * (I_DIM + 5), 2);
    ctrl_start = 1'b0;
    @(negedge ACLK);
    normal_run("relaunch", 1, 1'b0, 0);

    // Start edge during a run is ignored.
    clear_plan();
    setup(3, I_DIM, 1'b0, 1);
    plan_random(3, 1'b0, 3);
    start_pulse(1'b0);
    repeat (6) @(negedge ACLK);
    ctrl_start = 1'b1;
    @(negedge ACLK);
    ctrl_start = 1'b0;
    wait_end("mid_edge");
    check_end("mid_edge", 1'b1, 1'b0, 1 + 3 * (I_DIM + 6), 3);

    for (int r = 0; r < 4; r++) begin
      normal_run("rand", $urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    normal_run("h_max", H_MAX, 1'b0, 0);

    // Soft reset while waiting on the core for unit 2.
    clear_plan();
    setup(4, I_DIM, 1'b0, 0);
    plan_random(4, 1'b0, 2);
    start_pulse(1'b0);
    n = 0;
    while (!(writes_seen == 2 && core_busy && !core_start && stat_busy) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("srst_reached_wait", 64'(n < 200), 64'(1));
    ctrl_soft_rst = 1'b1;
    @(posedge ACLK);
    #1;
    check("srst_busy", 64'(stat_busy), 64'(0));
    check("srst_done_err", 64'({stat_done, stat_err}), 64'(0));
    check("srst_cycles", 64'(stat_cycles), 64'(0));
    check("srst_outputs", 64'({col_req, core_start, hbuf_we}), 64'(0));
    @(negedge ACLK);
    ctrl_soft_rst = 1'b0;
    repeat (3 * (I_DIM + 5)) @(negedge ACLK);
    check("srst_writes", 64'(writes_seen), 64'(2));
    check("srst_pending", 64'(exp_q.size()), 64'(0));
    check("srst_idle", 64'({stat_busy, stat_done, stat_err}), 64'(0));

    // Asynchronous reset while fetching drops the request without a clock edge.
    clear_plan();
    setup(2, I_DIM, 1'b0, 5);
    start_pulse(1'b0);
    n = 0;
    while (!col_req && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("arst_reached_fetch", 64'(col_req), 64'(1));
    #2 ARESETn = 1'b0;
    #1;
    check("arst_col_req", 64'(col_req), 64'(0));
    check("arst_status", 64'({stat_busy, stat_done, stat_err}), 64'(0));
    check("arst_cycles", 64'(stat_cycles), 64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    normal_run("after_arst", 1, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
